fft_sp_framer: RTL and testbench
================================

Name: fft_sp_framer

Overview:
- Parametrised successor to the FFT input serial-to-parallel stage.
- Accepts one complex sample per cycle and assembles NPOINT samples into one parallel frame for the butterfly datapath.
- Double-buffered (ping-pong), so input streams at full rate while the previous frame waits for the consumer.
- Adds valid/ready handshakes on both sides, runtime bit-reversed slot ordering, early-end frame error detection and an emitted-frame counter.

Parameters:
- DATA_W, 34: width of one complex sample; real part is [DATA_W-1:DATA_W/2], imaginary part is [DATA_W/2-1:0].
- NPOINT, 4: samples per frame; must be a power of two, 2..64.
- LOG2N, 2: log2(NPOINT); must equal log2(NPOINT) exactly.
- CNT_W, 16: width of frame_cnt.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-high (reset when 1, despite the name).
- in_valid  in  1  in_data is valid.
- in_ready  out  1  framer can accept a sample this cycle.
- in_data  in  DATA_W  serial complex sample.
- in_last  in  1  marks the final sample of a frame.
- bitrev_en  in  1  1 = store samples in bit-reversed slot order.
- out_valid  out  1  out_data holds a complete frame.
- out_ready  in  1  consumer takes the frame this cycle.
- out_data  out  NPOINT*DATA_W  frame; slot k is out_data[k*DATA_W +: DATA_W].
- frame_err  out  1  one-cycle pulse: frame ended early and was dropped.
- frame_cnt  out  CNT_W  count of frames emitted.

Behaviour:
- State: two banks B0/B1, each NPOINT x DATA_W, each with a full flag.
- Pointers: write-bank pointer wb, read-bank pointer rb, write index wr_idx (0..NPOINT-1), latched mode bit br.
- Reset (rst_n=1 at a clock edge) values:
  - wb=rb=0, wr_idx=0, both full flags cleared, bank contents 0.
  - out_valid=0, out_data=0, frame_err=0, frame_cnt=0.
  - in_ready=0 while rst_n=1; in_ready=1 on the first cycle after reset.
- Reset mid-frame discards all partial and full frames. No error pulse is generated.
- in_ready is the inverse of full[wb] (combinational from registers). A beat is accepted when in_valid&in_ready.
- On an accepted beat with wr_idx==0, br takes the value of bitrev_en. bitrev_en is ignored for the rest of the frame.
- Slot write address:
  - br=0: slot wr_idx.
  - br=1: bit-reverse of wr_idx over LOG2N bits. With NPOINT=4: idx 1 goes to slot 2, idx 2 goes to slot 1.
- Accepted beat with wr_idx<NPOINT-1 and in_last=0: wr_idx increments.
- Accepted beat with wr_idx==NPOINT-1 (in_last may be 0 or 1):
  - full[wb] is set, wb toggles, wr_idx returns to 0.
- Accepted beat with in_last=1 and wr_idx<NPOINT-1 (early end):
  - wr_idx returns to 0; full[wb] stays 0; the bank is overwritten by the next frame.
  - frame_err=1 on the next cycle only.
- Output side:
  - out_valid = full[rb]; out_data = contents of bank rb (registered storage, no combinational path from in_data).
  - When out_valid&out_ready: full[rb] clears, rb toggles, frame_cnt increments, wrapping 2^CNT_W-1 to 0.
- Latency: last sample accepted at edge T gives out_valid=1 in the cycle after T (1 cycle).
- Throughput: a sustained 1 sample/cycle with out_ready=1 never deasserts in_ready.
- Simultaneous events:
  - Completion into one bank and drain of the other bank in the same cycle are both honoured.
  - A bank drained at edge T is writable from the cycle after T (in_ready rises then). There is no same-cycle bypass.
- Full condition: with both banks full, in_ready=0. out_data and out_valid hold stable until out_ready.
- Empty condition: out_valid=0. out_data still holds the last contents of bank rb and must not be relied on.
- in_valid=0 gaps inside a frame are allowed; wr_idx holds.

Test Plan:
- Reset, then stream samples 1,2,3,4 (NPOINT=4, bitrev_en=0, out_ready=1) -> out_valid one cycle after sample 4 is accepted; slots 0..3 = 1,2,3,4; frame_cnt=1.
- Same stream with bitrev_en=1 on the first beat, then deasserted mid-frame -> slots 0..3 = 1,3,2,4.
- out_ready=0; stream 12 samples back-to-back -> in_ready falls after sample 8; first frame (1..4) held stable; raise out_ready -> frames 1..4 then 5..8 emitted in order; sample 9 accepted one cycle after the first drain.
- Send 2 samples with in_last=1 on the second -> frame_err pulses exactly 1 cycle, out_valid stays 0; the next 4 samples form a correct frame and frame_cnt=1.
- Assert rst_n for 1 cycle after 3 samples of a frame and with one full bank pending -> out_valid=0, frame_cnt=0, in_ready=1 the next cycle; the following 4 samples are emitted as slots 0..3.
- Preload frame_cnt near wrap (CNT_W=4) by emitting 16 frames -> frame_cnt reads 0 after the 16th.

Source files
------------

// File: rtl/fft_sp_framer.sv
// +--------------------------------------------------------------------------+
// | fft_sp_framer                                                            |
// | Ping-pong serial-to-parallel framer feeding the FFT butterfly datapath.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fft_sp_framer #(
    parameter int DATA_W = 34,
    parameter int NPOINT = 4,
    parameter int LOG2N  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    input  logic                     bitrev_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NPOINT*DATA_W-1:0] out_data,
    output logic                     frame_err,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam int               FRAME_W  = NPOINT * DATA_W;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(NPOINT - 1);

    function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    logic                 wb_q, wb_d;
    logic                 rb_q, rb_d;
    logic [1:0]           full_q, full_d;
    logic [LOG2N-1:0]     wr_idx_q, wr_idx_d;
    logic                 br_q, br_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 w_accept;
    logic                 w_drain;
    logic                 w_br;
    logic [LOG2N-1:0]     w_slot;
    logic [1:0][FRAME_W-1:0] w_bank;

    // Mode is sampled on the first beat so the slot order cannot change mid-frame.
    assign w_br     = (wr_idx_q == '0) ? bitrev_en : br_q;
    assign w_slot   = w_br ? f_bitrev(wr_idx_q) : wr_idx_q;
    assign w_accept = in_valid & in_ready;
    assign w_drain  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wb_q     <= 1'b0;
            rb_q     <= 1'b0;
            full_q   <= 2'b00;
            wr_idx_q <= '0;
            br_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wb_q     <= wb_d;
            rb_q     <= rb_d;
            full_q   <= full_d;
            wr_idx_q <= wr_idx_d;
            br_q     <= br_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Completion and drain always target different banks, so both may apply at once.
    always_comb begin
        wb_d     = wb_q;
        rb_d     = rb_q;
        full_d   = full_q;
        wr_idx_d = wr_idx_q;
        br_d     = br_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        if (w_accept) begin
            if (wr_idx_q == '0) begin
                br_d = bitrev_en;
            end
            if (wr_idx_q == LAST_IDX) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
                wr_idx_d     = '0;
            end else if (in_last) begin
                wr_idx_d = '0;
                err_d    = 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + LOG2N'(1);
            end
        end
        if (w_drain) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
            cnt_d        = cnt_q + CNT_W'(1);
        end
    end

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            localparam logic c_sel = 1'(b);
            logic [FRAME_W-1:0] bank_q;

            always_ff @(posedge clk) begin
                if (rst_n) begin
                    bank_q <= '0;
                end else if (w_accept && (wb_q == c_sel)) begin
                    for (int k = 0; k < NPOINT; k++) begin
                        if (w_slot == LOG2N'(k)) begin
                            bank_q[k*DATA_W +: DATA_W] <= in_data;
                        end
                    end
                end
            end

            assign w_bank[b] = bank_q;
        end
    endgenerate

    always_comb begin
        in_ready  = ~rst_n & ~full_q[wb_q];
        out_valid = full_q[rb_q];
        out_data  = w_bank[rb_q];
        frame_err = err_q;
        frame_cnt = cnt_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_sp_framer.sv
// +--------------------------------------------------------------------------+
// | tb_fft_sp_framer                                                         |
// | Scoreboard bench for fft_sp_framer with a frame-level reference model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fft_sp_framer;

    localparam int DW = 34;
    localparam int NP = 4;
    localparam int LG = 2;
    localparam int CW = 4;
    localparam int FW = NP * DW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          bitrev_en;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_data;
    logic          frame_err;
    logic [CW-1:0] frame_cnt;

    fft_sp_framer #(
        .DATA_W (DW),
        .NPOINT (NP),
        .LOG2N  (LG),
        .CNT_W  (CW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .bitrev_en (bitrev_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_pass = 0;
    int            ready_mode = 1;
    logic [FW-1:0] exp_q[$];
    logic [DW-1:0] part[$];
    bit            cur_br;
    bit            err_flag = 1'b0;
    logic [CW-1:0] exp_cnt = '0;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int rev_idx(input int i);
        int r = 0;
        int v = i;
        for (int b = 0; b < LG; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Reference model: collect accepted samples, emit a slot-ordered frame when NP arrive.
    task automatic model_accept(input logic [DW-1:0] d, input bit last, input bit br);
        logic [FW-1:0] f;
        if (part.size() == 0) cur_br = br;
        part.push_back(d);
        if (part.size() == NP) begin
            f = '0;
            for (int i = 0; i < NP; i++) begin
                int s;
                s = cur_br ? rev_idx(i) : i;
                f[s*DW +: DW] = part[i];
            end
            exp_q.push_back(f);
            part.delete();
        end else if (last) begin
            part.delete();
            err_flag = 1'b1;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        part.delete();
        err_flag = 1'b0;
    endtask

    task automatic set_mode(input int m);
        ready_mode = m;
        out_ready  = (m == 0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit last, input bit br, output int waits);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        bitrev_en = br;
        waits     = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits >= 300) begin
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected accept", waits);
                n_chk++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_accept(d, last, br);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic s1(input logic [DW-1:0] d, input bit last, input bit br);
        int w;
        send(d, last, br, w);
    endtask

    task automatic do_reset();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("in_ready_during_reset", FW'(in_ready), FW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom(), $urandom()});
    endfunction

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and tracks frame_err pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_cnt = '0;
        end else begin
            if (err_flag || frame_err) chk("frame_err_pulse", FW'(frame_err), FW'(err_flag));
            err_flag = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", out_data, '0);
                    if (out_data == '0) begin
                        n_pass--;
                        $display("FAIL unexpected_frame: got out_valid=1 expected no frame");
                    end
                end else begin
                    chk("frame_data", out_data, exp_q.pop_front());
                    chk("frame_cnt_at_emit", FW'(frame_cnt), FW'(exp_cnt));
                end
                exp_cnt = exp_cnt + CW'(1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            w;
        logic [FW-1:0] held;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        bitrev_en = 1'b0;

        do_reset();
        @(negedge clk);
        chk("reset_out_valid", FW'(out_valid), FW'(0));
        chk("reset_out_data", out_data, '0);
        chk("reset_frame_cnt", FW'(frame_cnt), FW'(0));
        chk("reset_frame_err", FW'(frame_err), FW'(0));
        chk("reset_in_ready", FW'(in_ready), FW'(1));
        @(posedge clk);
        #1;

        // Straight order and one-cycle latency.
        set_mode(0);
        for (int i = 1; i <= 4; i++) s1(DW'(i), i == 4, 1'b0);
        @(negedge clk);
        chk("latency_out_valid", FW'(out_valid), FW'(1));
        chk("straight_frame", out_data, {DW'(4), DW'(3), DW'(2), DW'(1)});
        idle(2);
        @(negedge clk);
        chk("frame_cnt_one", FW'(frame_cnt), FW'(1));
        @(posedge clk);
        #1;

        // Bit-reversed order latched on the first beat only.
        for (int i = 1; i <= 4; i++) s1(DW'(i), 1'b0, i == 1);
        @(negedge clk);
        chk("bitrev_frame", out_data, {DW'(4), DW'(2), DW'(3), DW'(1)});
        idle(3);

        // Back-pressure: both banks fill, then drain in order.
        do_reset();
        set_mode(1);
        for (int i = 1; i <= 8; i++) s1(DW'(i), 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = DW'(9);
        @(negedge clk);
        held = out_data;
        chk("full_out_valid", FW'(out_valid), FW'(1));
        repeat (2) @(negedge clk);
        chk("stall_after_8", FW'(in_ready), FW'(0));
        chk("hold_stable", out_data, held);
        chk("held_frame1", out_data, {DW'(4), DW'(3), DW'(2), DW'(1)});
        @(posedge clk);
        #1;
        set_mode(0);
        send(DW'(9), 1'b0, 1'b0, w);
        chk("accept_after_drain", FW'(w), FW'(1));
        for (int i = 10; i <= 12; i++) s1(DW'(i), 1'b0, 1'b0);
        idle(4);

        // Early end drops the frame and pulses frame_err.
        do_reset();
        set_mode(0);
        s1(rnd(), 1'b0, 1'b0);
        s1(rnd(), 1'b1, 1'b0);
        idle(3);
        @(negedge clk);
        chk("err_no_out_valid", FW'(out_valid), FW'(0));
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) s1(rnd(), i == 3, 1'b0);
        idle(3);
        @(negedge clk);
        chk("after_err_cnt", FW'(frame_cnt), FW'(1));
        @(posedge clk);
        #1;

        // Reset mid-frame with a full bank pending.
        do_reset();
        set_mode(1);
        for (int i = 0; i < 7; i++) s1(rnd(), 1'b0, 1'b0);
        do_reset();
        @(negedge clk);
        chk("midrst_out_valid", FW'(out_valid), FW'(0));
        chk("midrst_frame_cnt", FW'(frame_cnt), FW'(0));
        chk("midrst_in_ready", FW'(in_ready), FW'(1));
        @(posedge clk);
        #1;
        set_mode(0);
        for (int i = 1; i <= 4; i++) s1(DW'(i + 20), 1'b0, 1'b0);
        @(negedge clk);
        chk("midrst_frame", out_data, {DW'(24), DW'(23), DW'(22), DW'(21)});
        idle(3);

        // Counter wrap at 2^CW frames.
        do_reset();
        set_mode(0);
        for (int f = 0; f < 16; f++)
            for (int i = 0; i < 4; i++) s1(rnd(), 1'b0, 1'($urandom_range(0, 1)));
        idle(3);
        @(negedge clk);
        chk("cnt_wrap", FW'(frame_cnt), FW'(0));
        @(posedge clk);
        #1;

        // Randomised traffic with gaps, early ends and back-pressure.
        set_mode(2);
        for (int f = 0; f < 40; f++) begin
            bit early;
            int len;
            early = ($urandom_range(0, 9) == 0);
            len   = early ? $urandom_range(1, NP - 1) : NP;
            for (int i = 0; i < len; i++) begin
                bit lastb;
                lastb = (i == len - 1) ? (early ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
                s1(rnd(), lastb, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        set_mode(0);
        for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(posedge clk);
        #1;
        idle(2);
        chk("scoreboard_empty", FW'(exp_q.size()), FW'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
